// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter/sequencer in front of a shared M-bit 2:1 mux.
// Two valid/ready/last requesters compete for one registered output stage.
// A grant is held for a whole packet (until last) or until QUANTUM beats have been sent.
//
// Ports
//   mux2_rr_arbiter_port_clk       in   1  clock, rising edge
//   mux2_rr_arbiter_port_rst_n     in   1  asynchronous active-low reset
//   mux2_rr_arbiter_port_v0/d0/l0  in   requester 0 valid / data[M] / last
//   mux2_rr_arbiter_port_r0        out  requester 0 ready (combinational)
//   mux2_rr_arbiter_port_v1/d1/l1  in   requester 1 valid / data[M] / last
//   mux2_rr_arbiter_port_r1        out  requester 1 ready (combinational)
//   mux2_rr_arbiter_port_out_v     out  output beat valid (registered)
//   mux2_rr_arbiter_port_out_d     out  output beat data [M] (registered)
//   mux2_rr_arbiter_port_out_l     out  output last (registered)
//   mux2_rr_arbiter_port_out_src   out  source requester of output beat (registered)
//   mux2_rr_arbiter_port_out_rdy   in   downstream ready
//   mux2_rr_arbiter_port_sel       out  live mux select, 1 while requester 1 holds the grant

module mux2_rr_arbiter #(
   parameter int unsigned M       = 16,
   parameter int unsigned QUANTUM = 8
) (
   input  logic         mux2_rr_arbiter_port_clk,
   input  logic         mux2_rr_arbiter_port_rst_n,
   input  logic         mux2_rr_arbiter_port_v0,
   input  logic [M-1:0] mux2_rr_arbiter_port_d0,
   input  logic         mux2_rr_arbiter_port_l0,
   output logic         mux2_rr_arbiter_port_r0,
   input  logic         mux2_rr_arbiter_port_v1,
   input  logic [M-1:0] mux2_rr_arbiter_port_d1,
   input  logic         mux2_rr_arbiter_port_l1,
   output logic         mux2_rr_arbiter_port_r1,
   output logic         mux2_rr_arbiter_port_out_v,
   output logic [M-1:0] mux2_rr_arbiter_port_out_d,
   output logic         mux2_rr_arbiter_port_out_l,
   output logic         mux2_rr_arbiter_port_out_src,
   input  logic         mux2_rr_arbiter_port_out_rdy,
   output logic         mux2_rr_arbiter_port_sel
);

   localparam int unsigned CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(QUANTUM - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            granted_c;
   logic            cur_c;
   logic            cur_v_c;
   logic            cur_l_c;
   logic            other_v_c;
   logic            rdy_c;
   logic            accept_c;
   logic            rel_data_c;
   logic            rel_empty_c;
   logic [M-1:0]    mux_d_c;

   // Decode of the current grant and the handshake with the granted requester.
   assign granted_c   = (state_q == G0) || (state_q == G1);
   assign cur_c       = (state_q == G1);
   assign cur_v_c     = cur_c ? mux2_rr_arbiter_port_v1 : mux2_rr_arbiter_port_v0;
   assign cur_l_c     = cur_c ? mux2_rr_arbiter_port_l1 : mux2_rr_arbiter_port_l0;
   assign other_v_c   = cur_c ? mux2_rr_arbiter_port_v0 : mux2_rr_arbiter_port_v1;
   assign rdy_c       = !mux2_rr_arbiter_port_out_v || mux2_rr_arbiter_port_out_rdy;
   assign accept_c    = granted_c && cur_v_c && rdy_c;
   // Release after a beat (last or quantum used up) or when a fresh grant has nothing to send.
   assign rel_data_c  = accept_c && (cur_l_c || (cnt_q == CNT_LAST));
   assign rel_empty_c = granted_c && !cur_v_c && (cnt_q == '0);

   assign mux2_rr_arbiter_port_r0  = (state_q == G0) && rdy_c;
   assign mux2_rr_arbiter_port_r1  = (state_q == G1) && rdy_c;
   assign mux2_rr_arbiter_port_sel = cur_c;

   // Shared datapath mux, steered by the live grant.
   muxnx2 #(.M(M)) u_mux (
      .a   (mux2_rr_arbiter_port_d0),
      .b   (mux2_rr_arbiter_port_d1),
      .sel (cur_c),
      .y   (mux_d_c)
   );

   // State, round-robin pointer and beat counter.
   always_ff @(posedge mux2_rr_arbiter_port_clk or negedge mux2_rr_arbiter_port_rst_n) begin
      if (!mux2_rr_arbiter_port_rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (mux2_rr_arbiter_port_v0 || mux2_rr_arbiter_port_v1) begin
               cnt_d = '0;
               if (mux2_rr_arbiter_port_v0 && mux2_rr_arbiter_port_v1) begin
                  state_d = ptr_q ? G1 : G0;
               end else begin
                  state_d = mux2_rr_arbiter_port_v1 ? G1 : G0;
               end
            end
         end
         G0, G1: begin
            if (accept_c) begin
               cnt_d = cnt_q + CW'(1);
            end
            if (rel_data_c || rel_empty_c) begin
               cnt_d = '0;
               ptr_d = !cur_c;
               // Hand straight over to the other side, or keep streaming, without a bubble.
               if (other_v_c) begin
                  state_d = cur_c ? G0 : G1;
               end else if (rel_data_c && cur_v_c) begin
                  state_d = state_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // One-stage output register; a same-cycle drain and accept keeps out_v high.
   always_ff @(posedge mux2_rr_arbiter_port_clk or negedge mux2_rr_arbiter_port_rst_n) begin
      if (!mux2_rr_arbiter_port_rst_n) begin
         mux2_rr_arbiter_port_out_v   <= 1'b0;
         mux2_rr_arbiter_port_out_d   <= '0;
         mux2_rr_arbiter_port_out_l   <= 1'b0;
         mux2_rr_arbiter_port_out_src <= 1'b0;
      end else if (accept_c) begin
         mux2_rr_arbiter_port_out_v   <= 1'b1;
         mux2_rr_arbiter_port_out_d   <= mux_d_c;
         mux2_rr_arbiter_port_out_l   <= cur_l_c;
         mux2_rr_arbiter_port_out_src <= cur_c;
      end else if (mux2_rr_arbiter_port_out_v && mux2_rr_arbiter_port_out_rdy) begin
         mux2_rr_arbiter_port_out_v   <= 1'b0;
      end
   end

endmodule

// muxnx2: M-bit 2:1 mux, y = sel ? b : a.
//   a, b  in  M  data inputs
//   sel   in  1  select
//   y     out M  selected data (combinational)
module muxnx2 #(
   parameter int unsigned M = 16
) (
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   input  logic         sel,
   output logic [M-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter (M=16, QUANTUM=8).
module tb_mux2_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic        v0, l0, r0, v1, l1, r1;
   logic [15:0] d0, d1;
   logic        out_v, out_l, out_src, out_rdy, sel;
   logic [15:0] out_d;

   int checks;
   int failures;
   int cyc;

   typedef struct {
      logic [15:0] d;
      logic        l;
   } beat_t;

   typedef struct {
      logic [15:0] d;
      logic        l;
      logic        src;
   } exp_t;

   typedef struct {
      logic        v0;
      logic [15:0] d0;
      logic        l0;
      logic        v1;
      logic [15:0] d1;
      logic        l1;
      logic        e_sel;
      logic        e_r0;
      logic        e_r1;
      logic        e_ov;
      logic [15:0] e_d;
      logic        e_l;
      logic        e_src;
   } vec_t;

   beat_t q0[$];
   beat_t q1[$];
   exp_t  exp_q[$];
   int    out_cyc[$];
   logic  en0, en1;
   vec_t  tbl[9];

   mux2_rr_arbiter #(.M(16), .QUANTUM(8)) dut (
      .mux2_rr_arbiter_port_clk     (clk),
      .mux2_rr_arbiter_port_rst_n   (rst_n),
      .mux2_rr_arbiter_port_v0      (v0),
      .mux2_rr_arbiter_port_d0      (d0),
      .mux2_rr_arbiter_port_l0      (l0),
      .mux2_rr_arbiter_port_r0      (r0),
      .mux2_rr_arbiter_port_v1      (v1),
      .mux2_rr_arbiter_port_d1      (d1),
      .mux2_rr_arbiter_port_l1      (l1),
      .mux2_rr_arbiter_port_r1      (r1),
      .mux2_rr_arbiter_port_out_v   (out_v),
      .mux2_rr_arbiter_port_out_d   (out_d),
      .mux2_rr_arbiter_port_out_l   (out_l),
      .mux2_rr_arbiter_port_out_src (out_src),
      .mux2_rr_arbiter_port_out_rdy (out_rdy),
      .mux2_rr_arbiter_port_sel     (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add0(input logic [15:0] d, input logic l);
      beat_t b;
      b.d = d; b.l = l;
      q0.push_back(b);
   endtask

   task automatic add1(input logic [15:0] d, input logic l);
      beat_t b;
      b.d = d; b.l = l;
      q1.push_back(b);
   endtask

   task automatic expect_beat(input logic [15:0] d, input logic l, input logic src);
      exp_t e;
      e.d = d; e.l = l; e.src = src;
      exp_q.push_back(e);
   endtask

   // Present the head of each requester queue.
   task automatic drive();
      v0 = en0 && (q0.size() > 0);
      d0 = v0 ? q0[0].d : 16'h0;
      l0 = v0 ? q0[0].l : 1'b0;
      v1 = en1 && (q1.size() > 0);
      d1 = v1 ? q1[0].d : 16'h0;
      l1 = v1 ? q1[0].l : 1'b0;
   endtask

   task automatic monitor_pop();
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_extra: got beat %0h src %0d, expected no beat", out_d, out_src);
      end else begin
         e = exp_q.pop_front();
         chk("sb_d", 32'(out_d), 32'(e.d));
         chk("sb_l", 32'(out_l), 32'(e.l));
         chk("sb_src", 32'(out_src), 32'(e.src));
         out_cyc.push_back(cyc);
      end
   endtask

   // One clock: sample handshakes at negedge, retire accepted beats after posedge.
   task automatic step();
      logic a0, a1;
      beat_t tmp;
      @(negedge clk);
      a0 = v0 && r0;
      a1 = v1 && r1;
      if (out_v && out_rdy) monitor_pop();
      @(posedge clk);
      cyc++;
      if (a0 && q0.size() > 0) tmp = q0.pop_front();
      if (a1 && q1.size() > 0) tmp = q1.pop_front();
      #1;
      drive();
   endtask

   task automatic run(input int budget, input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout: %0d beats still outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic clear_all();
      en0 = 1'b0; en1 = 1'b0;
      q0.delete(); q1.delete(); exp_q.delete(); out_cyc.delete();
      drive();
   endtask

   task automatic do_reset();
      clear_all();
      out_rdy = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      checks = 0; failures = 0; cyc = 0;
      rst_n = 1'b0;
      out_rdy = 1'b1;
      clear_all();

      // Cycle table for both requesters sending two 2-beat packets back to back.
      tbl[0] = '{1'b1, 16'hA000, 1'b0, 1'b1, 16'hB000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 16'hA000, 1'b0, 1'b1, 16'hB000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 16'hA001, 1'b1, 1'b1, 16'hB000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA000, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 16'hA002, 1'b0, 1'b1, 16'hB000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA001, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 16'hA002, 1'b0, 1'b1, 16'hB001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hB000, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 16'hA002, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hB001, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 16'hA003, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA002, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA003, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

      // Reset held with both requesters valid, then first grant to requester 0.
      v0 = 1'b1; d0 = 16'h1111; v1 = 1'b1; d1 = 16'h2222;
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_v", 32'(out_v), 0);
      chk("rst_out_d", 32'(out_d), 0);
      chk("rst_out_l", 32'(out_l), 0);
      chk("rst_out_src", 32'(out_src), 0);
      chk("rst_r0", 32'(r0), 0);
      chk("rst_r1", 32'(r1), 0);
      chk("rst_sel", 32'(sel), 0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_r0", 32'(r0), 1);
      chk("post_rst_r1", 32'(r1), 0);
      chk("post_rst_sel", 32'(sel), 0);

      // Table-driven alternation: src 0,0,1,1,0,0 with no idle cycle.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         v0 = tbl[i].v0; d0 = tbl[i].d0; l0 = tbl[i].l0;
         v1 = tbl[i].v1; d1 = tbl[i].d1; l1 = tbl[i].l1;
         @(negedge clk);
         chk($sformatf("alt[%0d].sel", i), 32'(sel), 32'(tbl[i].e_sel));
         chk($sformatf("alt[%0d].r0", i), 32'(r0), 32'(tbl[i].e_r0));
         chk($sformatf("alt[%0d].r1", i), 32'(r1), 32'(tbl[i].e_r1));
         chk($sformatf("alt[%0d].out_v", i), 32'(out_v), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            chk($sformatf("alt[%0d].out_d", i), 32'(out_d), 32'(tbl[i].e_d));
            chk($sformatf("alt[%0d].out_l", i), 32'(out_l), 32'(tbl[i].e_l));
            chk($sformatf("alt[%0d].out_src", i), 32'(out_src), 32'(tbl[i].e_src));
         end
         @(posedge clk);
         #1;
      end

      // Single 3-beat packet from requester 0 on consecutive cycles, then idle.
      do_reset();
      add0(16'h0A0A, 1'b0); add0(16'h0B0B, 1'b0); add0(16'h0C0C, 1'b1);
      expect_beat(16'h0A0A, 1'b0, 1'b0);
      expect_beat(16'h0B0B, 1'b0, 1'b0);
      expect_beat(16'h0C0C, 1'b1, 1'b0);
      en0 = 1'b1;
      drive();
      run(30, "pkt3");
      checks++;
      if (out_cyc.size() != 3) begin
         failures++;
         $display("FAIL pkt3_count: got %0d beats expected 3", out_cyc.size());
      end else if (out_cyc[2] - out_cyc[0] != 2) begin
         failures++;
         $display("FAIL pkt3_consecutive: got span %0d expected 2", out_cyc[2] - out_cyc[0]);
      end
      repeat (3) step();
      chk("pkt3_idle_out_v", 32'(out_v), 0);
      chk("pkt3_idle_r0", 32'(r0), 0);
      chk("pkt3_idle_sel", 32'(sel), 0);

      // Quantum release: 12 beats from requester 1 interrupted after 8 by a packet from 0.
      do_reset();
      for (int i = 0; i < 12; i++) add1(16'(32'h4000 + i), (i == 11));
      add0(16'h5000, 1'b0); add0(16'h5001, 1'b1);
      for (int i = 0; i < 8; i++) expect_beat(16'(32'h4000 + i), 1'b0, 1'b1);
      expect_beat(16'h5000, 1'b0, 1'b0);
      expect_beat(16'h5001, 1'b1, 1'b0);
      for (int i = 8; i < 12; i++) expect_beat(16'(32'h4000 + i), (i == 11), 1'b1);
      en1 = 1'b1;
      drive();
      step();
      en0 = 1'b1;
      drive();
      run(60, "quantum");
      repeat (3) step();
      chk("quantum_idle_out_v", 32'(out_v), 0);

      // Downstream stall: output holds, no ready to either side, no loss afterwards.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         add0(16'(32'h6000 + i), (i == 5));
         expect_beat(16'(32'h6000 + i), (i == 5), 1'b0);
      end
      en0 = 1'b1;
      drive();
      n = 0;
      while (exp_q.size() > 3 && n < 20) begin
         step();
         n++;
      end
      out_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_out_v", 32'(out_v), 1);
         if (exp_q.size() > 0) begin
            chk("stall_out_d", 32'(out_d), 32'(exp_q[0].d));
            chk("stall_out_l", 32'(out_l), 32'(exp_q[0].l));
            chk("stall_out_src", 32'(out_src), 32'(exp_q[0].src));
         end
         chk("stall_r0", 32'(r0), 0);
         chk("stall_r1", 32'(r1), 0);
         @(posedge clk);
         #1;
      end
      out_rdy = 1'b1;
      drive();
      run(30, "stall");

      // Reset mid-packet while requester 1 holds the grant (pointer = 1).
      do_reset();
      add0(16'h7000, 1'b1);
      expect_beat(16'h7000, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         add1(16'(32'h7100 + i), (i == 3));
         expect_beat(16'(32'h7100 + i), (i == 3), 1'b1);
      end
      en0 = 1'b1; en1 = 1'b1;
      drive();
      n = 0;
      while (exp_q.size() > 3 && n < 20) begin
         step();
         n++;
      end
      chk("midrst_pre_out_v", 32'(out_v), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_v", 32'(out_v), 0);
      chk("midrst_out_d", 32'(out_d), 0);
      chk("midrst_r1", 32'(r1), 0);
      chk("midrst_sel", 32'(sel), 0);
      clear_all();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      add0(16'h7200, 1'b1);
      add1(16'h7300, 1'b1);
      expect_beat(16'h7200, 1'b1, 1'b0);
      expect_beat(16'h7300, 1'b1, 1'b1);
      en0 = 1'b1; en1 = 1'b1;
      drive();
      run(20, "midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
